irda_sir_rx_decoder: RTL and testbench

Parametrised IrDA SIR receive pulse decoder, the successor of the free-running 16× SIR decoder. It sits between the IR receiver pin and the UART receive path, clocked by the system clock and advanced by the baud-oversample tick (`fast_enable`). Compared with its predecessor it adds:
- input synchronisation and optional inversion;
- a minimum-pulse-width glitch filter;
- bit-phase lock to the first valid pulse instead of a free-running counter;
- a per-bit valid strobe;
- automatic return to idle after a run of pulse-free bits.

---
 rtl/irda_sir_rx_decoder.sv | 165 ++++++++++++++++
 tb/tb_irda_sir_rx_decoder.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irda_sir_rx_decoder.sv
// IrDA SIR receive pulse decoder.
// Synchronises the IR receiver output, rejects short pulses, locks bit timing to the first
// accepted pulse and emits one decoded UART-sense bit per OSR sample ticks. After IDLE_BITS
// pulse-free bits it drops back to idle. Transmit or FIR/MIR activity blanks the receiver.
module irda_sir_rx_decoder #(
  parameter int unsigned OSR         = 16,
  parameter int unsigned MIN_PULSE   = 2,
  parameter int unsigned IDLE_BITS   = 10,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RX_INVERT   = 1'b0
) (
  input  logic clk,
  input  logic wb_rst_n,
  input  logic rx_i,
  input  logic fast_enable,
  input  logic fast_mode,
  input  logic tx_select,
  output logic sir_dec_o,
  output logic sir_valid_o,
  output logic sir_active_o,
  output logic glitch_o
);

  localparam int unsigned PhaseW = $clog2(OSR);
  localparam int unsigned RunW   = $clog2(MIN_PULSE + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_BITS + 1);

  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(OSR - 1);
  // Phase of the tick following acceptance; phase 0 was the pulse's first sample.
  localparam logic [PhaseW-1:0] PhaseLock = PhaseW'(MIN_PULSE);
  localparam logic [RunW-1:0]   RunMax    = RunW'(MIN_PULSE);
  localparam logic [RunW-1:0]   RunAcc    = RunW'(MIN_PULSE - 1);
  localparam logic [IdleW-1:0]  IdleMax   = IdleW'(IDLE_BITS);

  typedef enum logic [0:0] {
    StIdle,
    StBit
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   blank;
  logic                   accepted;

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [RunW-1:0]   run_q, run_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              seen_q, seen_d;
  logic              dec_q, dec_d;
  logic              valid_q, valid_d;
  logic              glitch_q, glitch_d;

  // Synchroniser shift register; keeps running even while blanked.
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s  = sync_q[SYNC_STAGES-1] ^ RX_INVERT;
  assign blank = tx_select | fast_mode;

  // Next-state: glitch filter, bit-phase tracking, frame end detection and blanking.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    run_d    = run_q;
    idle_d   = idle_q;
    seen_d   = seen_q;
    dec_d    = dec_q;
    valid_d  = 1'b0;
    glitch_d = 1'b0;
    accepted = 1'b0;

    if (blank) begin
      state_d = StIdle;
      phase_d = '0;
      run_d   = '0;
      idle_d  = '0;
      seen_d  = 1'b0;
      dec_d   = 1'b1;
    end else if (fast_enable) begin
      // High-run counter saturates, so a long pulse is accepted only once.
      if (rx_s) begin
        if (run_q != RunMax) begin
          run_d = run_q + 1'b1;
        end
        accepted = (run_q == RunAcc);
      end else begin
        if ((run_q != '0) && (run_q != RunMax)) begin
          glitch_d = 1'b1;
        end
        run_d = '0;
      end

      unique case (state_q)
        StIdle: begin
          if (accepted) begin
            state_d = StBit;
            phase_d = PhaseLock;
            seen_d  = 1'b1;
            idle_d  = '0;
          end
        end
        StBit: begin
          if (phase_q == PhaseLast) begin
            phase_d = '0;
            dec_d   = ~seen_q;
            valid_d = 1'b1;
            // A pulse accepted on the closing tick belongs to the next bit.
            seen_d  = accepted;
            if (seen_q) begin
              idle_d = '0;
            end else begin
              idle_d = idle_q + 1'b1;
              if (idle_d == IdleMax) begin
                state_d = StIdle;
                idle_d  = '0;
                seen_d  = 1'b0;
              end
            end
          end else begin
            phase_d = phase_q + 1'b1;
            seen_d  = seen_q | accepted;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      run_q    <= '0;
      idle_q   <= '0;
      seen_q   <= 1'b0;
      dec_q    <= 1'b1;
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      seen_q   <= seen_d;
      dec_q    <= dec_d;
      valid_q  <= valid_d;
      glitch_q <= glitch_d;
    end
  end

  assign sir_dec_o    = dec_q;
  assign sir_valid_o  = valid_q;
  assign sir_active_o = (state_q == StBit);
  assign glitch_o     = glitch_q;

endmodule

// File: tb/tb_irda_sir_rx_decoder.sv
// Testbench for irda_sir_rx_decoder: directed and randomized pulse trains, each checked
// against a period-arithmetic model of the decoder built from the bit-timing rules.
module tb_irda_sir_rx_decoder;

  localparam int OSR  = 16;
  localparam int MP   = 2;
  localparam int IB   = 10;
  localparam int MAXC = 1024;

  logic clk         = 1'b0;
  logic wb_rst_n    = 1'b0;
  logic rx_i        = 1'b0;
  logic fast_enable = 1'b0;
  logic fast_mode   = 1'b0;
  logic tx_select   = 1'b0;
  logic sir_dec_o, sir_valid_o, sir_active_o, glitch_o;

  int errors = 0;
  int checks = 0;

  // Per-clock stimulus
  bit   rxc[MAXC];
  bit   fe[MAXC];
  bit   txs[MAXC];
  bit   fm[MAXC];
  // Per-clock observed outputs (sampled 1 time unit after the edge)
  logic ov[MAXC];
  logic og[MAXC];
  logic od[MAXC];
  logic oa[MAXC];
  // Per-clock expected outputs
  bit   ev[MAXC];
  bit   eg[MAXC];
  bit   ed[MAXC];
  bit   ea[MAXC];
  bit   evv[MAXC];
  bit   ast[MAXC];
  bit   aen[MAXC];
  int   ncyc;
  int   seg_tc[$];

  irda_sir_rx_decoder #(
    .OSR        (OSR),
    .MIN_PULSE  (MP),
    .IDLE_BITS  (IB),
    .SYNC_STAGES(2),
    .RX_INVERT  (1'b0)
  ) dut (
    .clk         (clk),
    .wb_rst_n    (wb_rst_n),
    .rx_i        (rx_i),
    .fast_enable (fast_enable),
    .fast_mode   (fast_mode),
    .tx_select   (tx_select),
    .sir_dec_o   (sir_dec_o),
    .sir_valid_o (sir_valid_o),
    .sir_active_o(sir_active_o),
    .glitch_o    (glitch_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_stim(input int n);
    ncyc = n;
    for (int c = 0; c < MAXC; c++) begin
      rxc[c] = 1'b0;
      fe[c]  = 1'b1;
      txs[c] = 1'b0;
      fm[c]  = 1'b0;
    end
  endtask

  // rx_s seen on tick edge c is rx_i driven two clocks earlier (two-stage synchroniser).
  task automatic set_pulse(input int first_tick, input int width);
    for (int i = 0; i < width; i++) rxc[first_tick - 2 + i] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_rst_n    = 1'b0;
    rx_i        = 1'b0;
    fast_enable = 1'b0;
    tx_select   = 1'b0;
    fast_mode   = 1'b0;
    repeat (3) @(negedge clk);
    wb_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_run();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rx_i        = rxc[c];
      fast_enable = fe[c];
      tx_select   = txs[c];
      fast_mode   = fm[c];
      @(posedge clk);
      #1;
      ov[c] = sir_valid_o;
      og[c] = glitch_o;
      od[c] = sir_dec_o;
      oa[c] = sir_active_o;
    end
    @(negedge clk);
    rx_i        = 1'b0;
    fast_enable = 1'b0;
    tx_select   = 1'b0;
    fast_mode   = 1'b0;
  endtask

  // Model one unblanked stretch of ticks (clock indices in seg_tc).
  task automatic model_segment();
    int  n;
    int  acc[$];
    bit  s[MAXC];
    bit  seen[64];
    int  k, len, i, t0, b, idle, cend, cb;
    n = seg_tc.size();
    for (int j = 0; j < n; j++) s[j] = (seg_tc[j] >= 2) ? rxc[seg_tc[j] - 2] : 1'b0;
    // High runs: long ones are accepted MP-1 ticks after their first sample,
    // short ones flag a glitch on the tick that ends them.
    k = 0;
    while (k < n) begin
      if (s[k]) begin
        len = 0;
        while ((k + len < n) && s[k + len]) len++;
        if (len >= MP) acc.push_back(k + MP - 1);
        else if (k + len < n) eg[seg_tc[k + len]] = 1'b1;
        k += len;
      end else begin
        k++;
      end
    end
    // Frames: bit b spans ticks [t0+b*OSR-1, t0+(b+1)*OSR-1) for acceptance purposes.
    i = 0;
    while (i < acc.size()) begin
      t0 = acc[i] - (MP - 1);
      for (int j = 0; j < 64; j++) seen[j] = 1'b0;
      for (int j = i; j < acc.size(); j++) begin
        b = (acc[j] - t0 + 1) / OSR;
        if (b < 64) seen[b] = 1'b1;
      end
      ast[seg_tc[acc[i]]] = 1'b1;
      idle = 0;
      cend = -1;
      for (b = 0; b < 64; b++) begin
        cb = t0 + OSR - 1 + b * OSR;
        if (cb >= n) break;
        ev[seg_tc[cb]]  = 1'b1;
        evv[seg_tc[cb]] = !seen[b];
        idle = seen[b] ? 0 : idle + 1;
        if (idle == IB) begin
          cend = cb;
          aen[seg_tc[cb]] = 1'b1;
          break;
        end
      end
      if (cend < 0) break;
      while ((i < acc.size()) && (acc[i] <= cend)) i++;
    end
  endtask

  task automatic build_expected();
    bit dec;
    bit act;
    for (int c = 0; c < MAXC; c++) begin
      ev[c]  = 1'b0;
      eg[c]  = 1'b0;
      evv[c] = 1'b0;
      ast[c] = 1'b0;
      aen[c] = 1'b0;
    end
    seg_tc.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (txs[c] || fm[c]) begin
        if (seg_tc.size() > 0) model_segment();
        seg_tc.delete();
      end else if (fe[c]) begin
        seg_tc.push_back(c);
      end
    end
    if (seg_tc.size() > 0) model_segment();
    dec = 1'b1;
    act = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (txs[c] || fm[c]) begin
        dec = 1'b1;
        act = 1'b0;
      end
      if (ev[c]) dec = evv[c];
      if (ast[c]) act = 1'b1;
      if (aen[c]) act = 1'b0;
      ed[c] = dec;
      ea[c] = act;
    end
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    fast_enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rx_i = (c >= 10) ? 1'b1 : c[0];
      @(posedge clk);
      #1;
      checks++;
      if ({sir_dec_o, sir_valid_o, sir_active_o, glitch_o} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=1000", c,
                 {sir_dec_o, sir_valid_o, sir_active_o, glitch_o});
      end
    end
    @(negedge clk);
    wb_rst_n = 1'b1;
    rx_i = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({sir_dec_o, sir_valid_o, sir_active_o, glitch_o} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_after cyc=%0d got=%b exp=1000", c,
                 {sir_dec_o, sir_valid_o, sir_active_o, glitch_o});
      end
    end
    // Lock onto a pulse, then assert reset between edges: outputs must clear at once.
    clear_stim(30);
    set_pulse(5, 3);
    drive_run();
    checks += 2;
    if (oa[29] !== 1'b1) begin
      errors++;
      $display("FAIL reset_prelock active got=%b exp=1", oa[29]);
    end
    if (od[29] !== 1'b0) begin
      errors++;
      $display("FAIL reset_prelock dec got=%b exp=0", od[29]);
    end
    @(posedge clk);
    #3;
    wb_rst_n = 1'b0;
    #1;
    checks++;
    if ({sir_dec_o, sir_valid_o, sir_active_o, glitch_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async got=%b exp=1000",
               {sir_dec_o, sir_valid_o, sir_active_o, glitch_o});
    end
    @(negedge clk);
    wb_rst_n = 1'b1;
  endtask

  task automatic test_single_pulse();
    int nstb;
    do_reset();
    clear_stim(230);
    set_pulse(20, 3);
    build_expected();
    drive_run();
    for (int c = 0; c < ncyc; c++) begin
      checks += 4;
      if (ov[c] !== ev[c]) begin
        errors++; $display("FAIL single_valid clk=%0d got=%b exp=%b", c, ov[c], ev[c]);
      end
      if (od[c] !== ed[c]) begin
        errors++; $display("FAIL single_dec clk=%0d got=%b exp=%b", c, od[c], ed[c]);
      end
      if (oa[c] !== ea[c]) begin
        errors++; $display("FAIL single_active clk=%0d got=%b exp=%b", c, oa[c], ea[c]);
      end
      if (og[c] !== eg[c]) begin
        errors++; $display("FAIL single_glitch clk=%0d got=%b exp=%b", c, og[c], eg[c]);
      end
    end
    checks += 8;
    if ({oa[20], oa[21]} !== 2'b01) begin
      errors++; $display("FAIL single_lock_edge got=%b exp=01", {oa[20], oa[21]});
    end
    if ({ov[35], od[35]} !== 2'b10) begin
      errors++; $display("FAIL single_first_bit got=%b exp=10", {ov[35], od[35]});
    end
    if ({ov[51], od[51]} !== 2'b11) begin
      errors++; $display("FAIL single_second_bit got=%b exp=11", {ov[51], od[51]});
    end
    if ({oa[194], oa[195], ov[195]} !== 3'b101) begin
      errors++; $display("FAIL single_frame_end got=%b exp=101", {oa[194], oa[195], ov[195]});
    end
    nstb = 0;
    for (int c = 0; c < ncyc; c++) if (ov[c] === 1'b1) nstb++;
    if (nstb != 11) begin
      errors++; $display("FAIL single_strobe_count got=%0d exp=11", nstb);
    end
    if (ov[34] !== 1'b0 || ov[36] !== 1'b0) begin
      errors++; $display("FAIL single_strobe_width got=%b%b exp=00", ov[34], ov[36]);
    end
    if (oa[229] !== 1'b0) begin
      errors++; $display("FAIL single_idle_end got=%b exp=0", oa[229]);
    end
    if (og[23] !== 1'b0) begin
      errors++; $display("FAIL single_no_glitch got=%b exp=0", og[23]);
    end
  endtask

  task automatic test_glitch();
    int ng;
    do_reset();
    clear_stim(80);
    set_pulse(40, 1);
    build_expected();
    drive_run();
    ng = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks += 4;
      if (ov[c] !== ev[c]) begin
        errors++; $display("FAIL glitch_valid clk=%0d got=%b exp=%b", c, ov[c], ev[c]);
      end
      if (od[c] !== ed[c]) begin
        errors++; $display("FAIL glitch_dec clk=%0d got=%b exp=%b", c, od[c], ed[c]);
      end
      if (oa[c] !== ea[c]) begin
        errors++; $display("FAIL glitch_active clk=%0d got=%b exp=%b", c, oa[c], ea[c]);
      end
      if (og[c] !== eg[c]) begin
        errors++; $display("FAIL glitch_strobe clk=%0d got=%b exp=%b", c, og[c], eg[c]);
      end
      if (og[c] === 1'b1) ng++;
    end
    checks += 2;
    if (og[41] !== 1'b1) begin
      errors++; $display("FAIL glitch_at_41 got=%b exp=1", og[41]);
    end
    if (ng != 1) begin
      errors++; $display("FAIL glitch_count got=%0d exp=1", ng);
    end
  endtask

  task automatic test_frame();
    bit [9:0] bitv;
    int       dq[$];
    bitv = {1'b1, 8'h55, 1'b0};
    do_reset();
    clear_stim(340);
    for (int j = 0; j < 10; j++) if (!bitv[j]) set_pulse(10 + 16 * j, 3);
    build_expected();
    drive_run();
    for (int c = 0; c < ncyc; c++) begin
      checks += 4;
      if (ov[c] !== ev[c]) begin
        errors++; $display("FAIL frame_valid clk=%0d got=%b exp=%b", c, ov[c], ev[c]);
      end
      if (od[c] !== ed[c]) begin
        errors++; $display("FAIL frame_dec clk=%0d got=%b exp=%b", c, od[c], ed[c]);
      end
      if (oa[c] !== ea[c]) begin
        errors++; $display("FAIL frame_active clk=%0d got=%b exp=%b", c, oa[c], ea[c]);
      end
      if (og[c] !== eg[c]) begin
        errors++; $display("FAIL frame_glitch clk=%0d got=%b exp=%b", c, og[c], eg[c]);
      end
      if (ov[c] === 1'b1) dq.push_back(int'(od[c]));
    end
    checks += 2;
    if (dq.size() != 19) begin
      errors++; $display("FAIL frame_strobe_count got=%0d exp=19", dq.size());
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if ((j < dq.size()) ? (dq[j] != int'(bitv[j])) : 1'b1) begin
        errors++;
        $display("FAIL frame_bit%0d got=%0d exp=%0d", j, (j < dq.size()) ? dq[j] : -1,
                 bitv[j]);
      end
    end
    if (oa[339] !== 1'b0) begin
      errors++; $display("FAIL frame_end_idle got=%b exp=0", oa[339]);
    end
  endtask

  task automatic test_blanking();
    int nstb;
    do_reset();
    clear_stim(400);
    for (int j = 0; j < 8; j += 2) set_pulse(10 + 16 * j, 3);
    for (int c = 66; c <= 130; c++) txs[c] = 1'b1;
    for (int c = 150; c <= 170; c++) fm[c] = 1'b1;
    set_pulse(160, 15);
    build_expected();
    drive_run();
    nstb = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks += 4;
      if (ov[c] !== ev[c]) begin
        errors++; $display("FAIL blank_valid clk=%0d got=%b exp=%b", c, ov[c], ev[c]);
      end
      if (od[c] !== ed[c]) begin
        errors++; $display("FAIL blank_dec clk=%0d got=%b exp=%b", c, od[c], ed[c]);
      end
      if (oa[c] !== ea[c]) begin
        errors++; $display("FAIL blank_active clk=%0d got=%b exp=%b", c, oa[c], ea[c]);
      end
      if (og[c] !== eg[c]) begin
        errors++; $display("FAIL blank_glitch clk=%0d got=%b exp=%b", c, og[c], eg[c]);
      end
      if ((c >= 66) && (c < 186) && (ov[c] === 1'b1)) nstb++;
    end
    checks += 5;
    if ({oa[65], oa[66]} !== 2'b10) begin
      errors++; $display("FAIL blank_drop_active got=%b exp=10", {oa[65], oa[66]});
    end
    if ({od[65], od[66]} !== 2'b01) begin
      errors++; $display("FAIL blank_force_dec got=%b exp=01", {od[65], od[66]});
    end
    if (nstb != 0) begin
      errors++; $display("FAIL blank_no_strobes got=%0d exp=0", nstb);
    end
    if ({oa[171], oa[172]} !== 2'b01) begin
      errors++; $display("FAIL blank_release_lock got=%b exp=01", {oa[171], oa[172]});
    end
    if ({ov[186], od[186]} !== 2'b10) begin
      errors++; $display("FAIL blank_release_bit got=%b exp=10", {ov[186], od[186]});
    end
  endtask

  task automatic test_tick_rate();
    int sc[$];
    do_reset();
    clear_stim(800);
    for (int c = 0; c < 800; c++) fe[c] = ((c % 4) == 3);
    for (int c = 80; c < 92; c++) rxc[c] = 1'b1;
    build_expected();
    drive_run();
    for (int c = 0; c < ncyc; c++) begin
      checks += 4;
      if (ov[c] !== ev[c]) begin
        errors++; $display("FAIL rate_valid clk=%0d got=%b exp=%b", c, ov[c], ev[c]);
      end
      if (od[c] !== ed[c]) begin
        errors++; $display("FAIL rate_dec clk=%0d got=%b exp=%b", c, od[c], ed[c]);
      end
      if (oa[c] !== ea[c]) begin
        errors++; $display("FAIL rate_active clk=%0d got=%b exp=%b", c, oa[c], ea[c]);
      end
      if (og[c] !== eg[c]) begin
        errors++; $display("FAIL rate_glitch clk=%0d got=%b exp=%b", c, og[c], eg[c]);
      end
      if (ov[c] === 1'b1) sc.push_back(c);
    end
    checks += 4;
    if ({oa[86], oa[87]} !== 2'b01) begin
      errors++; $display("FAIL rate_lock got=%b exp=01", {oa[86], oa[87]});
    end
    if (sc.size() != 11) begin
      errors++; $display("FAIL rate_strobe_count got=%0d exp=11", sc.size());
    end
    if ((sc.size() > 0) ? (sc[0] != 143) : 1'b1) begin
      errors++; $display("FAIL rate_first_strobe got=%0d exp=143", (sc.size() > 0) ? sc[0] : -1);
    end
    if ({oa[782], oa[783]} !== 2'b10) begin
      errors++; $display("FAIL rate_frame_end got=%b exp=10", {oa[782], oa[783]});
    end
    for (int j = 1; j < sc.size(); j++) begin
      checks++;
      if (sc[j] - sc[j-1] != 64) begin
        errors++; $display("FAIL rate_spacing idx=%0d got=%0d exp=64", j, sc[j] - sc[j-1]);
      end
    end
  endtask

  task automatic test_random_frames();
    bit [9:0] bitv;
    int       base, st, w, jit;
    int       dq[$];
    for (int it = 0; it < 4; it++) begin
      bitv = {1'b1, 8'($urandom), 1'b0};
      base = 10 + $urandom_range(0, 5);
      do_reset();
      clear_stim(360);
      for (int j = 0; j < 10; j++) begin
        jit = (j == 0) ? 0 : $urandom_range(0, 4) - 2;
        w   = $urandom_range(2, 6);
        st  = base + 16 * j + jit;
        if (!bitv[j]) set_pulse(st, w);
        if ((j > 0) && ($urandom_range(0, 3) == 0)) set_pulse(base + 16 * j + 11, 1);
      end
      build_expected();
      drive_run();
      dq.delete();
      for (int c = 0; c < ncyc; c++) begin
        checks += 4;
        if (ov[c] !== ev[c]) begin
          errors++; $display("FAIL rand_valid it=%0d clk=%0d got=%b exp=%b", it, c, ov[c], ev[c]);
        end
        if (od[c] !== ed[c]) begin
          errors++; $display("FAIL rand_dec it=%0d clk=%0d got=%b exp=%b", it, c, od[c], ed[c]);
        end
        if (oa[c] !== ea[c]) begin
          errors++; $display("FAIL rand_active it=%0d clk=%0d got=%b exp=%b", it, c, oa[c], ea[c]);
        end
        if (og[c] !== eg[c]) begin
          errors++; $display("FAIL rand_glitch it=%0d clk=%0d got=%b exp=%b", it, c, og[c], eg[c]);
        end
        if (ov[c] === 1'b1) dq.push_back(int'(od[c]));
      end
      for (int j = 0; j < 10; j++) begin
        checks++;
        if ((j < dq.size()) ? (dq[j] != int'(bitv[j])) : 1'b1) begin
          errors++;
          $display("FAIL rand_bit it=%0d bit=%0d got=%0d exp=%0d", it, j,
                   (j < dq.size()) ? dq[j] : -1, bitv[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch();
    test_frame();
    test_blanking();
    test_tick_rate();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
